alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
//
// PURPOSE
//   Shares one ALU core (dut_top/alu_core) between NUM_REQ requesters.
//   - Round-robin selects one pending request and latches its operands.
//   - Issues the operation to the ALU as a one-cycle start pulse, then waits for alu_done.
//   - Returns the result tagged with the requester id over a valid/ready response channel.
//   - Sits between the requester interfaces and the ALU; serves one operation at a time.
//
// PARAMETERS
//   NUM_REQ  4   number of requesters (>=2)
//   DATA_W   8   operand width
//   OP_W     4   ALU opcode width
//   TIMEOUT  16  cycles in WAIT before an error response (only with ALU_TIMEOUT_EN)
//
// PORTS
//   clk          in   1                clock, rising edge
//   reset        in   1                asynchronous, active-low reset
//   req_valid    in   NUM_REQ          per-requester request pending
//   req_ready    out  NUM_REQ          one-hot accept; request g transfers when req_valid[g]&req_ready[g]
//   req_a        in   NUM_REQ*DATA_W   operand A, requester g at [g*DATA_W +: DATA_W]
//   req_b        in   NUM_REQ*DATA_W   operand B, same packing
//   req_op       in   NUM_REQ*OP_W     opcode, requester g at [g*OP_W +: OP_W]
//   alu_start    out  1                one-cycle pulse: ALU operands valid
//   alu_a        out  DATA_W           latched operand A
//   alu_b        out  DATA_W           latched operand B
//   alu_op       out  OP_W             latched opcode
//   alu_done     in   1                ALU result valid (one-cycle pulse)
//   alu_result   in   2*DATA_W         ALU result (full multiply width)
//   rsp_valid    out  1                response valid
//   rsp_id       out  $clog2(NUM_REQ)  requester index of the response
//   rsp_result   out  2*DATA_W         captured alu_result
//   rsp_err      out  1                1 = timed out, result invalid
//   rsp_ready    in   1                consumer accepts the response
//   busy         out  1                state != IDLE
//
// BEHAVIOUR
//   Reset:
//   - On reset low, immediately: state=IDLE, RR pointer=0, and every output=0,
//     including alu_a/b/op, rsp_id and rsp_result.
//   - Any in-flight operation is discarded and its response is never produced.
//   FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   - IDLE: winner g = first set req_valid bit searching from ptr upward, mod NUM_REQ.
//     - req_ready=onehot(g), combinational; all zero if no request is pending.
//     - On transfer: latch a/b/op and id=g, set ptr=(g+1)%NUM_REQ, go to ISSUE.
//   - ISSUE: alu_start=1 for exactly one cycle; go to WAIT.
//   - WAIT: on alu_done, capture alu_result into rsp_result, rsp_err=0, go to RESP.
//   - RESP: rsp_valid=1; rsp_id/result/err held stable until rsp_ready=1, then go to IDLE.
//   - req_ready=0 in ISSUE, WAIT and RESP.
//   Latency:
//   - Accept at cycle N -> alu_start at N+1.
//   - alu_done at cycle M>=N+2 -> rsp_valid from M+1.
//   - Throughput: at most one operation per 4 cycles.
//   Boundary conditions:
//   - alu_done outside WAIT (incl. the ISSUE cycle) is ignored.
//   - rsp_ready while rsp_valid=0 is ignored.
//   - A request appearing while busy waits; it is not lost, because the requester holds req_valid.
//   - req_valid dropped before transfer: no grant is recorded and ptr is unchanged.
//   - alu_a/b/op hold their last latched values after the operation.
//
// CONFIGURATION
//   ALU_TIMEOUT_EN defined:
//   - A counter clears on entry to WAIT and increments each WAIT cycle.
//   - If the counter reaches TIMEOUT without alu_done: go to RESP with rsp_err=1 and rsp_result=0.
//   - A late alu_done is then ignored.
//   ALU_TIMEOUT_EN undefined:
//   - No counter; WAIT lasts until alu_done.
//   - rsp_err is tied to 0 and TIMEOUT is unused.
//
// TESTING
//   1 Single op: req0 a=8'h05 b=8'h03 op=ADD, alu_done 2 cycles after alu_start with 16'h0008
//     -> rsp_valid, id=0, result=16'h0008, err=0; exactly one alu_start.
//   2 RR fairness: all 4 req_valid high from reset, rsp_ready=1
//     -> grant order 0,1,2,3,0; with only 1 and 3 held high, grants alternate 1,3,1,3.
//   3 Backpressure: rsp_ready low 5 cycles in RESP
//     -> rsp_valid/id/result stable, req_ready=0, no alu_start; accept resumes the cycle after rsp_ready=1.
//   4 Timeout (ALU_TIMEOUT_EN, TIMEOUT=16): alu_done never asserted
//     -> rsp_valid with err=1, result=0 after 16 WAIT cycles; alu_done pulse 3 cycles later has no effect.
//   5 Reset mid-op: reset low during WAIT
//     -> all outputs 0 at once, ptr=0; a stale alu_done after release gives no response;
//        a following req2 is served normally.
//   6 Spurious done: alu_done pulse in IDLE and ISSUE
//     -> no rsp_valid, no state change except the normal ISSUE->WAIT.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one multi-cycle ALU among NUM_REQ requesters.
// Optional macro ALU_TIMEOUT_EN: abort WAIT after TIMEOUT cycles with an error response.
module alu_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int OP_W    = 4,
  parameter int TIMEOUT = 16,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic                      alu_start,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [OP_W-1:0]           alu_op,
  input  logic                      alu_done,
  input  logic [2*DATA_W-1:0]       alu_result,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [2*DATA_W-1:0]       rsp_result,
  output logic                      rsp_err,
  input  logic                      rsp_ready,
  output logic                      busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                          state_q, state_d;
  logic [ID_W-1:0]                 ptr_q, ptr_d, id_q, id_d, gnt_id, cand;
  logic [ID_W:0]                   sum;
  logic                            gnt_found;
  logic [DATA_W-1:0]               a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]                 op_q, op_d;
  logic [2*DATA_W-1:0]             res_q, res_d;
  logic [NUM_REQ-1:0][DATA_W-1:0]  a_lane, b_lane;
  logic [NUM_REQ-1:0][OP_W-1:0]    op_lane;

`ifdef ALU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign a_lane[g]  = req_a[g*DATA_W +: DATA_W];
    assign b_lane[g]  = req_b[g*DATA_W +: DATA_W];
    assign op_lane[g] = req_op[g*OP_W +: OP_W];
  end

  // Rotating priority search starting at ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    sum       = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      cand = sum[ID_W-1:0];
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  // Gated by reset so every output reads zero while reset is held.
  assign req_ready = (state_q == S_IDLE && reset && gnt_found) ? (NUM_REQ'(1) << gnt_id) : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
`ifdef ALU_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: if (gnt_found) begin
        a_d     = a_lane[gnt_id];
        b_d     = b_lane[gnt_id];
        op_d    = op_lane[gnt_id];
        id_d    = gnt_id;
        ptr_d   = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
`ifdef ALU_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (alu_done) begin
          res_d   = alu_result;
`ifdef ALU_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = S_RESP;
        end
`ifdef ALU_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

`ifdef ALU_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign alu_start  = (state_q == S_ISSUE);
  assign rsp_valid  = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign rsp_id     = id_q;
  assign rsp_result = res_q;

endmodule
